// File: rtl/boot_load_ctrl_pkg.sv
// Shared definitions for the bootloader.
//   BITS            data word width
//   ADDRW           byte-address width of data memory
//   BOOT_MAX_WORDS  largest word count a header may announce
//   boot_state_t    loader sequencer states
package boot_load_ctrl_pkg;

    localparam int          BITS           = 32;
    localparam int          ADDRW          = 15;
    localparam int unsigned BOOT_MAX_WORDS = 2 ** (ADDRW - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } boot_state_t;

endpackage

// File: rtl/boot_load_ctrl_byte_packer.sv
// boot_byte_packer: assembles four bytes, first byte into [7:0], into a
// 32-bit word. Used for both the header and the data words.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_clr          synchronous clear of the byte counter
//   i_byte_vld     i_byte is valid this cycle
//   i_byte         incoming byte
//   o_word_vld     pulse in the cycle the 4th byte arrives
//   o_word         assembled word, valid with o_word_vld
module boot_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_buf <= 24'd0;
        end else if (i_clr) begin
            r_cnt <= 2'd0;
        end else if (i_byte_vld) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_buf[7:0]   <= i_byte;
                2'd1:    r_buf[15:8]  <= i_byte;
                2'd2:    r_buf[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    // The 4th byte is forwarded combinationally so the word is usable in
    // the same cycle it completes.
    assign o_word_vld = i_byte_vld && !i_clr && (r_cnt == 2'd3);
    assign o_word     = {i_byte, r_buf};

endmodule

// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: owns the data-memory bootload write port during program
// load. Parses a 4-byte little-endian word-count header N, then packs N
// little-endian words and writes each at index*4. Holds the core in reset
// while loading.
// Optional feature macro: BOOT_TIMEOUT_EN (inter-byte timeout abort).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   boot_start     pulse, begin a load (only honoured in IDLE)
//   rx_vld/rx_byte UART byte strobe and data
//   bootloading    loader owns memory write port
//   we_boot        one-cycle word write strobe
//   wdata_addr     byte address of the write (word aligned)
//   wdata_data     packed write word
//   cpu_rst_n      active-low core reset
//   boot_done      last load completed
//   boot_err       last load aborted
module boot_load_ctrl
    import boot_load_ctrl_pkg::*;
#(
    parameter int          BITS        = boot_load_ctrl_pkg::BITS,
    parameter int          ADDRW       = boot_load_ctrl_pkg::ADDRW,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             boot_start,
    input  logic             rx_vld,
    input  logic [7:0]       rx_byte,
    output logic             bootloading,
    output logic             we_boot,
    output logic [ADDRW-1:0] wdata_addr,
    output logic [BITS-1:0]  wdata_data,
    output logic             cpu_rst_n,
    output logic             boot_done,
    output logic             boot_err
);

    localparam int          IW        = ADDRW - 2;
    localparam int unsigned MAX_WORDS = 2 ** IW;

    boot_state_t      r_state, w_next;
    logic [IW-1:0]    r_idx;
    logic [IW:0]      r_n;        // one bit wider than the index: N may equal MAX_WORDS
    logic [ADDRW-1:0] r_addr;
    logic [BITS-1:0]  r_data;
    logic             r_done, r_err, r_cpu_rst_n;

    logic             w_start, w_collect, w_byte_vld, w_word_vld, w_hdr_err, w_timeout;
    logic [31:0]      w_word;
    logic [IW:0]      w_idx_inc;

    assign w_start    = (r_state == IDLE) && boot_start;
    assign w_collect  = (r_state == HDR) || (r_state == DATA);
    assign w_byte_vld = rx_vld && w_collect;
    assign w_idx_inc  = {1'b0, r_idx} + (IW+1)'(1);

    boot_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_start || w_timeout),
        .i_byte_vld (w_byte_vld),
        .i_byte     (rx_byte),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    // Counts idle cycles between bytes; restarts on every byte and stays
    // cleared outside the collecting states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_to_cnt <= 32'd0;
        else if (!w_collect || rx_vld) r_to_cnt <= 32'd0;
        else                           r_to_cnt <= r_to_cnt + 32'd1;
    end

    assign w_timeout = w_collect && !rx_vld && (r_to_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state
    always_comb begin
        w_next    = r_state;
        w_hdr_err = 1'b0;
        case (r_state)
            IDLE:  if (boot_start) w_next = HDR;
            HDR:   if (w_word_vld) begin
                       if (w_word == 32'd0)
                           w_next = DONE;
                       else if (w_word > 32'(MAX_WORDS)) begin
                           w_hdr_err = 1'b1;
                           w_next    = IDLE;
                       end else
                           w_next = DATA;
                   end
            DATA:  if (w_word_vld) w_next = WRITE;
            WRITE: w_next = (w_idx_inc == r_n) ? DONE : DATA;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_timeout) w_next = IDLE;
    end

    // Datapath and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_n         <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            // Core runs whenever the loader is (about to be) idle; this
            // releases it one cycle after DONE, after ownership is returned.
            r_cpu_rst_n <= (w_next == IDLE);
            if (w_start) begin
                r_idx  <= '0;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_next == DONE)         r_done <= 1'b1;
            if (w_hdr_err || w_timeout) r_err  <= 1'b1;
            if (r_state == HDR && w_word_vld)
                r_n <= w_word[IW:0];
            if (r_state == DATA && w_word_vld) begin
                r_addr <= {r_idx, 2'b00};
                r_data <= BITS'(w_word);
            end
            if (r_state == WRITE)
                r_idx <= r_idx + 1'b1;
        end
    end

    assign bootloading = w_collect || (r_state == WRITE);
    assign we_boot     = (r_state == WRITE);
    assign wdata_addr  = r_addr;
    assign wdata_data  = r_data;
    assign cpu_rst_n   = r_cpu_rst_n;
    assign boot_done   = r_done;
    assign boot_err    = r_err;

endmodule

// File: tb/tb_boot_load_ctrl.sv
module tb_boot_load_ctrl;

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned TO = 100;
`else
    localparam int unsigned TO = 5_000_000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_start;
    logic        rx_vld;
    logic [7:0]  rx_byte;
    logic        bootloading, we_boot, cpu_rst_n, boot_done, boot_err;
    logic [14:0] wdata_addr;
    logic [31:0] wdata_data;

    int tests = 0;
    int fails = 0;

    logic [14:0] wr_addr[$];
    logic [31:0] wr_data[$];

    boot_load_ctrl #(.BITS(32), .ADDRW(15), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .boot_start  (boot_start),
        .rx_vld      (rx_vld),
        .rx_byte     (rx_byte),
        .bootloading (bootloading),
        .we_boot     (we_boot),
        .wdata_addr  (wdata_addr),
        .wdata_data  (wdata_data),
        .cpu_rst_n   (cpu_rst_n),
        .boot_done   (boot_done),
        .boot_err    (boot_err)
    );

    always #5 clk = ~clk;

    // Write log: one entry per cycle we_boot is high, so a stretched
    // strobe shows up as an extra entry.
    always @(negedge clk) begin
        if (we_boot) begin
            wr_addr.push_back(wdata_addr);
            wr_data.push_back(wdata_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_vld  = 1'b1;
        step(1);
        rx_vld  = 1'b0;
        step(gap);
    endtask

    task automatic start_load();
        boot_start = 1'b1;
        step(1);
        boot_start = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".bootloading"}, {31'd0, bootloading}, 32'd0);
        chk({tag, ".we_boot"},     {31'd0, we_boot},     32'd0);
        chk({tag, ".addr"},        {17'd0, wdata_addr},  32'd0);
        chk({tag, ".data"},        wdata_data,           32'd0);
        chk({tag, ".cpu_rst_n"},   {31'd0, cpu_rst_n},   32'd0);
        chk({tag, ".done"},        {31'd0, boot_done},   32'd0);
        chk({tag, ".err"},         {31'd0, boot_err},    32'd0);
    endtask

    initial begin
        rst_n = 1'b0; boot_start = 1'b0; rx_vld = 1'b0; rx_byte = 8'h00;
        step(3);
        chk_reset_outs("rst");

        // Release reset, idle
        rst_n = 1'b1;
        step(1);
        chk("idle.cpu_rst_n_first", {31'd0, cpu_rst_n}, 32'd1);
        step(10);
        chk("idle.cpu_rst_n", {31'd0, cpu_rst_n},   32'd1);
        chk("idle.bootload",  {31'd0, bootloading}, 32'd0);
        chk("idle.nowrites",  wr_addr.size(),       32'd0);

        // Two-word load
        start_load();
        chk("ld2.bootload_hdr", {31'd0, bootloading}, 32'd1);
        chk("ld2.cpu_rst_hdr",  {31'd0, cpu_rst_n},   32'd0);
        send_byte(8'h02, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 0);
        chk("ld2.w0.we",   {31'd0, we_boot},   32'd1);
        chk("ld2.w0.addr", {17'd0, wdata_addr}, 32'h0000);
        chk("ld2.w0.data", wdata_data,         32'h12345678);
        step(1);
        chk("ld2.w0.we_off", {31'd0, we_boot}, 32'd0);
        send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 0);
        chk("ld2.w1.we",   {31'd0, we_boot},   32'd1);
        chk("ld2.w1.addr", {17'd0, wdata_addr}, 32'h0004);
        chk("ld2.w1.data", wdata_data,         32'hDEADBEEF);
        chk("ld2.w1.cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        step(1);
        chk("ld2.done.we",       {31'd0, we_boot},     32'd0);
        chk("ld2.done.bootload", {31'd0, bootloading}, 32'd0);
        chk("ld2.done.done",     {31'd0, boot_done},   32'd1);
        chk("ld2.done.cpu_rst",  {31'd0, cpu_rst_n},   32'd0);
        step(1);
        chk("ld2.idle.cpu_rst",  {31'd0, cpu_rst_n},   32'd1);
        chk("ld2.idle.done",     {31'd0, boot_done},   32'd1);
        chk("ld2.idle.err",      {31'd0, boot_err},    32'd0);
        chk("ld2.nwrites",       wr_addr.size(),       32'd2);
        chk("ld2.log0.addr",     {17'd0, wr_addr[0]},  32'h0000);
        chk("ld2.log0.data",     wr_data[0],           32'h12345678);
        chk("ld2.log1.addr",     {17'd0, wr_addr[1]},  32'h0004);
        chk("ld2.log1.data",     wr_data[1],           32'hDEADBEEF);

        // N == 0
        step(2);
        start_load();
        chk("n0.done_cleared", {31'd0, boot_done}, 32'd0);
        send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 0);
        chk("n0.done",     {31'd0, boot_done},   32'd1);
        chk("n0.err",      {31'd0, boot_err},    32'd0);
        chk("n0.bootload", {31'd0, bootloading}, 32'd0);
        step(1);
        chk("n0.cpu_rst",  {31'd0, cpu_rst_n},   32'd1);
        chk("n0.nwrites",  wr_addr.size(),       32'd2);

        // N = 8193 (one over max)
        step(2);
        start_load();
        send_byte(8'h01, 1); send_byte(8'h20, 1); send_byte(8'h00, 1); send_byte(8'h00, 0);
        chk("big.err",      {31'd0, boot_err},    32'd1);
        chk("big.done",     {31'd0, boot_done},   32'd0);
        chk("big.bootload", {31'd0, bootloading}, 32'd0);
        chk("big.cpu_rst",  {31'd0, cpu_rst_n},   32'd1);
        step(3);
        chk("big.idle_bootload", {31'd0, bootloading}, 32'd0);
        chk("big.nwrites",  wr_addr.size(),       32'd2);

        // Reset mid-load (after one full word and 2 bytes of the next)
        start_load();
        chk("rl.err_cleared", {31'd0, boot_err}, 32'd0);
        send_byte(8'h02, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 0);
        chk("rl.w0.data", wdata_data, 32'h04030201);
        step(1);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        chk("rl.pre.bootload", {31'd0, bootloading}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("rl.async");
        step(2);
        rst_n = 1'b1;
        step(2);
        start_load();
        send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_byte(8'h44, 1); send_byte(8'h33, 1); send_byte(8'h22, 1); send_byte(8'h11, 0);
        chk("rl.new.we",   {31'd0, we_boot},    32'd1);
        chk("rl.new.addr", {17'd0, wdata_addr}, 32'h0000);
        chk("rl.new.data", wdata_data,          32'h11223344);
        step(1);
        chk("rl.new.done", {31'd0, boot_done},  32'd1);
        step(1);
        chk("rl.nwrites",  wr_addr.size(),      32'd4);
        chk("rl.log3.addr", {17'd0, wr_addr[3]}, 32'h0000);
        chk("rl.log3.data", wr_data[3],          32'h11223344);

`ifdef BOOT_TIMEOUT_EN
        // Stall after one header byte
        step(2);
        start_load();
        send_byte(8'h05, 0);
        step(TO - 1);
        chk("to.pre.err",      {31'd0, boot_err},    32'd0);
        chk("to.pre.bootload", {31'd0, bootloading}, 32'd1);
        step(1);
        chk("to.err",      {31'd0, boot_err},    32'd1);
        chk("to.bootload", {31'd0, bootloading}, 32'd0);
        chk("to.cpu_rst",  {31'd0, cpu_rst_n},   32'd1);
        chk("to.nwrites",  wr_addr.size(),       32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
